multicycle_ctrl: RTL
====================

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16: maximum consecutive cycles spent waiting on mem_ready before faulting.
REQ-002 SHALL have port clk, input, 1: single clock, rising-edge.
REQ-003 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-004 SHALL have port opcode, input, 7: instruction register opcode, stable from DECODE until next FETCH.
REQ-005 SHALL have port zero, input, 1: ALU zero flag.
REQ-006 SHALL have port mem_ready, input, 1: memory completes current request this cycle.
REQ-007 SHALL have ports pc_write, adr_src, mem_req, mem_write, ir_write, reg_write, err, all output, 1: PC enable, address mux (0=PC, 1=ALUOut), memory request, store, IR enable, register-file write, fault flag.
REQ-008 SHALL have ports alu_src_a, alu_src_b, result_src, alu_op, all output, 2: A mux (00 PC, 01 OldPC, 10 rs1), B mux (00 rs2, 01 imm, 10 const 4), result mux (00 ALUOut, 01 read data, 10 ALU result), ALU op class (00 add, 01 subtract, 10 funct-decode).
REQ-009 SHALL have port state_o, output, 4: current state encoding, for debug.

Function
REQ-010 SHALL be a Moore FSM with states FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BEQ, FAULT; outputs not listed for a state are 0.
REQ-011 FETCH SHALL drive mem_req=1, adr_src=0, alu_src_a=00, alu_src_b=10, alu_op=00, result_src=10, and ir_write=pc_write=mem_ready; it SHALL stay in FETCH until mem_ready=1, then go to DECODE.
REQ-012 DECODE SHALL drive alu_src_a=01, alu_src_b=01, alu_op=00; next state by opcode: 0000011/0100011 -> MEMADR, 0110011 -> EXECR, 0010011 -> EXECI, 1100011 -> BEQ, any other -> FAULT.
REQ-013 MEMADR SHALL drive alu_src_a=10, alu_src_b=01, alu_op=00; next MEMREAD for load, MEMWRITE for store.
REQ-014 MEMREAD SHALL drive mem_req=1, adr_src=1; SHALL hold until mem_ready=1, then go to MEMWB.
REQ-015 MEMWB SHALL drive result_src=01, reg_write=1; next FETCH.
REQ-016 MEMWRITE SHALL drive mem_req=1, mem_write=1, adr_src=1; SHALL hold until mem_ready=1, then go to FETCH.
REQ-017 EXECR SHALL drive alu_src_a=10, alu_src_b=00, alu_op=10; EXECI SHALL drive alu_src_a=10, alu_src_b=01, alu_op=00; both go next to ALUWB.
REQ-018 ALUWB SHALL drive result_src=00, reg_write=1; next FETCH.
REQ-019 BEQ SHALL drive alu_src_a=10, alu_src_b=00, alu_op=01, result_src=00, pc_write=zero; next FETCH.
REQ-020 Instruction latency SHALL be: load 5 cycles, store 4, R/I 4, branch 3, each plus memory wait cycles.
REQ-021 A wait counter SHALL increment each cycle in FETCH, MEMREAD or MEMWRITE with mem_ready=0, and SHALL clear on any state change or on mem_ready=1.
REQ-022 When the counter reaches TIMEOUT-1 with mem_ready still 0, next state SHALL be FAULT; if mem_ready=1 in that same cycle, normal completion SHALL take priority.
REQ-023 FAULT SHALL drive err=1 and all other outputs 0, and SHALL be left only by reset.
REQ-024 mem_write SHALL never be 1 unless mem_req=1.

Reset
REQ-025 reset=1 SHALL asynchronously force state FETCH, wait counter 0, err 0.
REQ-026 While reset=1, mem_req, pc_write and ir_write SHALL be forced to 0; all other outputs SHALL take FETCH values.
REQ-027 Reset asserted mid-instruction (including in a wait state) SHALL abandon the instruction; first FETCH request SHALL occur on the first clk edge after deassertion.

Structure
REQ-028 State enum, opcode constants and mux/ALU-op encodings SHALL live in shared package ctrl_pkg.
REQ-029 The wait counter and timeout compare SHALL be a sub-module mem_wait_timer (inputs clk, reset, waiting, done; output expired).

Verification
REQ-030 lw, opcode 0000011, mem_ready=1 always -> state sequence FETCH, DECODE, MEMADR, MEMREAD, MEMWB; reg_write=1 with result_src=01 in cycle 5 only.
REQ-031 sw, opcode 0100011, mem_ready low 3 cycles in MEMWRITE -> mem_write=1 held 4 cycles, no reg_write, return to FETCH.
REQ-032 beq, opcode 1100011, zero=1 then zero=0 -> pc_write=1 in BEQ for the first, 0 for the second.
REQ-033 opcode 1111111 -> FAULT after DECODE, err=1 held until reset, then FETCH with err=0.
REQ-034 TIMEOUT=4, mem_ready held 0 in FETCH -> FAULT entered after 4 wait cycles; with mem_ready=1 on the 4th cycle -> DECODE instead.
REQ-035 reset pulsed while in MEMREAD -> immediate FETCH, mem_req=0 during reset, counter 0.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle control unit:
// state enum, opcodes, mux selects and per-state control word.
package ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_FAULT    = 4'd10
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_RDATA  = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    // Control outputs that depend only on the state.
    typedef struct packed {
        logic       mem_req;
        logic       adr_src;
        logic       mem_write;
        logic       reg_write;
        logic       err;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] result_src;
        logic [1:0] alu_op;
    } ctrl_t;

    function automatic ctrl_t state_ctrl(state_t s);
        ctrl_t c;
        c = '0;
        unique case (s)
            S_FETCH: begin
                c.mem_req    = 1'b1;
                c.alu_src_a  = SRCA_PC;
                c.alu_src_b  = SRCB_FOUR;
                c.alu_op     = ALU_ADD;
                c.result_src = RES_ALU;
            end
            S_DECODE: begin
                c.alu_src_a = SRCA_OLDPC;
                c.alu_src_b = SRCB_IMM;
                c.alu_op    = ALU_ADD;
            end
            S_MEMADR, S_EXECI: begin
                c.alu_src_a = SRCA_RS1;
                c.alu_src_b = SRCB_IMM;
                c.alu_op    = ALU_ADD;
            end
            S_MEMREAD: begin
                c.mem_req = 1'b1;
                c.adr_src = 1'b1;
            end
            S_MEMWB: begin
                c.result_src = RES_RDATA;
                c.reg_write  = 1'b1;
            end
            S_MEMWRITE: begin
                c.mem_req   = 1'b1;
                c.mem_write = 1'b1;
                c.adr_src   = 1'b1;
            end
            S_EXECR: begin
                c.alu_src_a = SRCA_RS1;
                c.alu_src_b = SRCB_RS2;
                c.alu_op    = ALU_FUNCT;
            end
            S_ALUWB: begin
                c.result_src = RES_ALUOUT;
                c.reg_write  = 1'b1;
            end
            S_BEQ: begin
                c.alu_src_a  = SRCA_RS1;
                c.alu_src_b  = SRCB_RS2;
                c.alu_op     = ALU_SUB;
                c.result_src = RES_ALUOUT;
            end
            S_FAULT: begin
                c.err = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts consecutive cycles stalled on memory and flags
// the cycle in which the stall budget runs out.
module mem_wait_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic waiting,
    input  logic done,
    output logic expired
);

    localparam int W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [W-1:0] count;

    // A completing request in the last cycle wins over the timeout.
    assign expired = waiting && !done &&
                     (count == W'(TIMEOUT - 1));

    // Stall counter: restarts whenever the stall ends.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            count <= '0;
        else if (!waiting || done || expired)
            count <= '0;
        else
            count <= count + W'(1);
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Moore control FSM for a multicycle RISC-V datapath with
// a memory-stall watchdog that parks the core in FAULT.
module multicycle_ctrl
    import ctrl_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       adr_src,
    output logic       mem_req,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_write,
    output logic       err,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] result_src,
    output logic [1:0] alu_op,
    output logic [3:0] state_o
);

    state_t state;
    state_t nxt;
    ctrl_t  ctl;
    logic   waiting;
    logic   expired;

    assign waiting = (state == S_FETCH)   ||
                     (state == S_MEMREAD) ||
                     (state == S_MEMWRITE);

    mem_wait_timer #(
        .TIMEOUT(TIMEOUT)
    ) u_timer (
        .clk    (clk),
        .reset  (reset),
        .waiting(waiting),
        .done   (mem_ready),
        .expired(expired)
    );

    // Next-state decode.
    always_comb begin
        nxt = state;
        unique case (state)
            S_FETCH: begin
                if (mem_ready)
                    nxt = S_DECODE;
                else if (expired)
                    nxt = S_FAULT;
            end
            S_DECODE: begin
                case (opcode)
                    OP_LOAD, OP_STORE: nxt = S_MEMADR;
                    OP_RTYPE:          nxt = S_EXECR;
                    OP_ITYPE:          nxt = S_EXECI;
                    OP_BRANCH:         nxt = S_BEQ;
                    default:           nxt = S_FAULT;
                endcase
            end
            S_MEMADR:
                nxt = (opcode == OP_STORE) ? S_MEMWRITE
                                           : S_MEMREAD;
            S_MEMREAD: begin
                if (mem_ready)
                    nxt = S_MEMWB;
                else if (expired)
                    nxt = S_FAULT;
            end
            S_MEMWRITE: begin
                if (mem_ready)
                    nxt = S_FETCH;
                else if (expired)
                    nxt = S_FAULT;
            end
            S_EXECR, S_EXECI: nxt = S_ALUWB;
            S_MEMWB, S_ALUWB, S_BEQ: nxt = S_FETCH;
            S_FAULT: nxt = S_FAULT;
            default: nxt = S_FAULT;
        endcase
    end

    // State plus registered control word for the next state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_FETCH;
            ctl   <= state_ctrl(S_FETCH);
        end else begin
            state <= nxt;
            ctl   <= state_ctrl(nxt);
        end
    end

    // Enables that follow handshake/flag inputs, all held
    // off while reset is asserted.
    assign mem_req   = ctl.mem_req & ~reset;
    assign mem_write = ctl.mem_write & mem_req;
    assign ir_write  = ~reset & (state == S_FETCH) & mem_ready;
    assign pc_write  = ~reset &
                       (((state == S_FETCH) & mem_ready) |
                        ((state == S_BEQ) & zero));

    assign adr_src    = ctl.adr_src;
    assign reg_write  = ctl.reg_write;
    assign err        = ctl.err;
    assign alu_src_a  = ctl.alu_src_a;
    assign alu_src_b  = ctl.alu_src_b;
    assign result_src = ctl.result_src;
    assign alu_op     = ctl.alu_op;
    assign state_o    = state;

endmodule
